// File: rtl/timer_pkg.sv
// Shared constants for the timer counter and its prescaler.
package timer_pkg;

    localparam int unsigned CNT_W_DEF = 64;
    localparam int unsigned DIV_W_DEF = 8;
    localparam int unsigned HALF_W    = CNT_W_DEF / 2;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a one-cycle tick every div_val+1 running clocks, or every running clock when bypassed.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             halt_en,
    output logic             tick
);

    logic [DIV_W-1:0] pre_cnt_q;
    logic [DIV_W-1:0] pre_cnt_d;
    logic             run;
    logic             at_div;

    // Halt holds pre_cnt so counting resumes mid-period; a lowered div_val simply wraps through all-ones.
    always_comb begin
        run       = timer_en & ~halt_en;
        at_div    = (pre_cnt_q == div_val);
        pre_cnt_d = pre_cnt_q;
        if (!timer_en || !div_en) begin
            pre_cnt_d = '0;
        end else if (run) begin
            pre_cnt_d = at_div ? '0 : pre_cnt_q + DIV_W'(1);
        end
        tick = div_en ? (run & at_div) : run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/timer_cnt.sv
// Free-running timer counter with half-word loads, compare match and sticky interrupt status.
module timer_cnt
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               timer_en,
    input  logic               div_en,
    input  logic [DIV_W-1:0]   div_val,
    input  logic               halt_en,
    input  logic               cnt_wr_lo,
    input  logic               cnt_wr_hi,
    input  logic [CNT_W/2-1:0] wdata,
    input  logic [CNT_W-1:0]   cmp_val,
    input  logic               int_en,
    input  logic               int_clr,
    output logic [CNT_W-1:0]   cnt,
    output logic               int_st,
    output logic               tim_int
);

    localparam int unsigned HW = CNT_W / 2;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             int_st_q;
    logic             int_st_d;
    logic             match;
    logic             tick;

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .timer_en (timer_en),
        .div_en   (div_en),
        .div_val  (div_val),
        .halt_en  (halt_en),
        .tick     (tick)
    );

    // Writes take priority over the tick; the unwritten half keeps its value.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_wr_lo || cnt_wr_hi) begin
            if (cnt_wr_lo) cnt_d[HW-1:0]     = wdata;
            if (cnt_wr_hi) cnt_d[CNT_W-1:HW] = wdata;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        match    = (cnt_q == cmp_val);
        int_st_d = int_st_q;
        if (match) begin
            int_st_d = 1'b1;
        end else if (int_clr) begin
            int_st_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            int_st_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            int_st_q <= int_st_d;
        end
    end

    assign cnt     = cnt_q;
    assign int_st  = int_st_q;
    assign tim_int = int_st_q & int_en;

endmodule

// File: tb/tb_timer_cnt.sv
// Scoreboard bench for timer_cnt: expectations are queued as stimulus is driven and popped at each sample point.
module tb_timer_cnt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        timer_en;
    logic        div_en;
    logic [7:0]  div_val;
    logic        halt_en;
    logic        cnt_wr_lo;
    logic        cnt_wr_hi;
    logic [31:0] wdata;
    logic [63:0] cmp_val;
    logic        int_en;
    logic        int_clr;
    logic [63:0] cnt;
    logic        int_st;
    logic        tim_int;

    typedef struct {
        string       name;
        logic [63:0] cnt;
        logic        st;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    timer_cnt #(.CNT_W(64), .DIV_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .timer_en  (timer_en),
        .div_en    (div_en),
        .div_val   (div_val),
        .halt_en   (halt_en),
        .cnt_wr_lo (cnt_wr_lo),
        .cnt_wr_hi (cnt_wr_hi),
        .wdata     (wdata),
        .cmp_val   (cmp_val),
        .int_en    (int_en),
        .int_clr   (int_clr),
        .cnt       (cnt),
        .int_st    (int_st),
        .tim_int   (tim_int)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void push(input string n, input logic [63:0] c, input logic s);
        exp_t x;
        x.name = n;
        x.cnt  = c;
        x.st   = s;
        sb.push_back(x);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; timer_en = 1'b1; div_en = 1'b0; div_val = 8'd0; halt_en = 1'b0;
        cnt_wr_lo = 1'b0; cnt_wr_hi = 1'b0; wdata = '0; cmp_val = '1; int_en = 1'b0; int_clr = 1'b0;
        step(2);
        push("reset_hold", 64'd0, 1'b0);
        e = sb.pop_front(); checks++;
        if (cnt !== e.cnt || int_st !== e.st) begin
            errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
        end
        checks++;
        if (tim_int !== 1'b0) begin errors++; $display("FAIL reset_tim_int: got %b expected 0", tim_int); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push($sformatf("post_reset_%0d", i), 64'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            e = sb.pop_front(); checks++;
            if (cnt !== e.cnt || int_st !== e.st) begin
                errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
            end
        end
    endtask

    task automatic test_prescale;
        timer_en = 1'b0; cnt_wr_lo = 1'b1; cnt_wr_hi = 1'b1; wdata = '0;
        push("wr_zero", 64'd0, 1'b0);
        step();
        cnt_wr_lo = 1'b0; cnt_wr_hi = 1'b0;
        timer_en = 1'b1; div_en = 1'b1; div_val = 8'd3;
        push("div3_k3", 64'd0, 1'b0);
        push("div3_k4", 64'd1, 1'b0);
        push("div3_k40", 64'd10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) step(3);
            if (k == 2) step();
            if (k == 3) step(36);
            e = sb.pop_front(); checks++;
            if (cnt !== e.cnt || int_st !== e.st) begin
                errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
            end
        end
        timer_en = 1'b0; cnt_wr_lo = 1'b1; cnt_wr_hi = 1'b1;
        step();
        cnt_wr_lo = 1'b0; cnt_wr_hi = 1'b0; div_val = 8'd0; timer_en = 1'b1;
        push("div0_k40", 64'd40, 1'b0);
        step(40);
        e = sb.pop_front(); checks++;
        if (cnt !== e.cnt || int_st !== e.st) begin
            errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
        end
    endtask

    task automatic test_halt;
        timer_en = 1'b0; cnt_wr_lo = 1'b1; cnt_wr_hi = 1'b1; wdata = '0;
        step();
        cnt_wr_lo = 1'b0; cnt_wr_hi = 1'b0; timer_en = 1'b1; div_val = 8'd3;
        // Six clocks: one tick at the fourth, leaving the prescaler at 2.
        push("before_halt", 64'd1, 1'b0);
        push("halted_10", 64'd1, 1'b0);
        push("release_1", 64'd1, 1'b0);
        push("release_2", 64'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: step(6);
                1: begin halt_en = 1'b1; step(10); end
                2: begin halt_en = 1'b0; step(); end
                default: step();
            endcase
            e = sb.pop_front(); checks++;
            if (cnt !== e.cnt || int_st !== e.st) begin
                errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
            end
        end
    endtask

    task automatic test_write_wrap;
        div_en = 1'b0; cnt_wr_hi = 1'b1; wdata = 32'hFFFF_FFFF;
        push("wr_hi_tick", 64'hFFFF_FFFF_0000_0002, 1'b0);
        push("wr_lo_tick", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        push("count_max", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        push("wrap_zero", 64'd0, 1'b1);
        push("after_wrap", 64'd1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) begin cnt_wr_hi = 1'b0; cnt_wr_lo = 1'b1; wdata = 32'hFFFF_FFFE; end
            if (k == 1) cnt_wr_lo = 1'b0;
            e = sb.pop_front(); checks++;
            if (cnt !== e.cnt || int_st !== e.st) begin
                errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
            end
        end
    endtask

    task automatic test_compare;
        timer_en = 1'b0; cnt_wr_lo = 1'b1; cnt_wr_hi = 1'b1; wdata = '0; int_clr = 1'b1; cmp_val = 64'd5;
        push("cmp_setup", 64'd0, 1'b0);
        push("cmp_reach", 64'd5, 1'b0);
        push("cmp_set", 64'd5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: step();
                1: begin cnt_wr_lo = 1'b0; cnt_wr_hi = 1'b0; int_clr = 1'b0; timer_en = 1'b1; step(5); end
                default: begin halt_en = 1'b1; step(); end
            endcase
            e = sb.pop_front(); checks++;
            if (cnt !== e.cnt || int_st !== e.st) begin
                errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
            end
        end
        checks++;
        if (tim_int !== 1'b0) begin errors++; $display("FAIL tim_int_masked: got %b expected 0", tim_int); end
        int_en = 1'b1;
        #1;
        checks++;
        if (tim_int !== 1'b1) begin errors++; $display("FAIL tim_int_comb: got %b expected 1", tim_int); end
        push("clr_vs_match", 64'd5, 1'b1);
        push("cmp_moved", 64'd6, 1'b1);
        push("clr_after", 64'd7, 1'b0);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin int_clr = 1'b1; step(); int_clr = 1'b0; end
                1: begin halt_en = 1'b0; step(); end
                default: begin int_clr = 1'b1; step(); int_clr = 1'b0; end
            endcase
            e = sb.pop_front(); checks++;
            if (cnt !== e.cnt || int_st !== e.st) begin
                errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
            end
        end
        checks++;
        if (tim_int !== 1'b0) begin errors++; $display("FAIL tim_int_cleared: got %b expected 0", tim_int); end
    endtask

    task automatic test_async_reset;
        timer_en = 1'b0; cmp_val = 64'h1234; cnt_wr_hi = 1'b1; wdata = '0;
        push("load_1234", 64'h1234, 1'b0);
        push("match_1234", 64'h1234, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                step();
                cnt_wr_hi = 1'b0; cnt_wr_lo = 1'b1; wdata = 32'h1234;
                step();
                cnt_wr_lo = 1'b0;
            end else begin
                step();
            end
            e = sb.pop_front(); checks++;
            if (cnt !== e.cnt || int_st !== e.st) begin
                errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
            end
        end
        #2;
        rst_n = 1'b0;
        push("async_reset", 64'd0, 1'b0);
        #1;
        e = sb.pop_front(); checks++;
        if (cnt !== e.cnt || int_st !== e.st) begin
            errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
        end
        checks++;
        if (tim_int !== 1'b0) begin errors++; $display("FAIL async_tim_int: got %b expected 0", tim_int); end
    endtask

    task automatic test_cmp_zero_reset;
        cmp_val = '0; int_en = 1'b0;
        step();
        rst_n = 1'b1;
        push("cmp0_released", 64'd0, 1'b0);
        push("cmp0_first_clk", 64'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) step();
            e = sb.pop_front(); checks++;
            if (cnt !== e.cnt || int_st !== e.st) begin
                errors++; $display("FAIL %s: cnt=%h int_st=%b, expected cnt=%h int_st=%b", e.name, cnt, int_st, e.cnt, e.st);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_halt();
        test_write_wrap();
        test_compare();
        test_async_reset();
        test_cmp_zero_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_cnt.md
Name: timer_cnt

Overview:
- 64-bit free-running timer counter with programmable prescaler, compare-match flag and interrupt output.
- Sits directly downstream of the halt controller and consumes its halt_en. When the debugger halts the core, halt_en freezes the count.
- Register-file writes load the counter and configure compare and interrupt behaviour.

Parameters:
- CNT_W, 64, counter and compare width; must be even. Write halves are CNT_W/2 each.
- DIV_W, 8, width of the prescaler divide value.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- timer_en  input  1  counting enable from control register
- div_en  input  1  1 = use prescaler; 0 = count every clk
- div_val  input  DIV_W  prescaler value; tick period = div_val+1 clks
- halt_en  input  1  debug halt from halt controller; freezes counting
- cnt_wr_lo  input  1  one-cycle strobe: load cnt[CNT_W/2-1:0] from wdata
- cnt_wr_hi  input  1  one-cycle strobe: load cnt[CNT_W-1:CNT_W/2] from wdata
- wdata  input  CNT_W/2  write data for counter halves
- cmp_val  input  CNT_W  compare value
- int_en  input  1  interrupt enable
- int_clr  input  1  one-cycle strobe: clear int_st
- cnt  output  CNT_W  current count (registered)
- int_st  output  1  sticky compare-match status
- tim_int  output  1  interrupt = int_st & int_en (combinational)

Behaviour:
- Reset (rst_n low, async):
  - cnt = 0, prescaler count pre_cnt = 0, int_st = 0, tim_int = 0.
  - Mid-operation reset clears everything immediately; no pending state survives.
- Run condition: run = timer_en & ~halt_en.
- Prescaler (pre_cnt, DIV_W bits):
  - timer_en = 0 or div_en = 0: pre_cnt forced to 0.
  - div_en = 1 and run = 1: pre_cnt counts 0..div_val. tick = (pre_cnt == div_val), and pre_cnt returns to 0 on that cycle.
  - div_val = 0: tick every clk.
  - halt_en = 1 with timer_en = 1: pre_cnt holds its value. Counting resumes from the held value when halt drops.
  - div_val changed mid-count below the current pre_cnt: pre_cnt continues to all-ones, wraps to 0, then ticks on reaching div_val. No special handling.
- Tick source:
  - div_en = 0: tick = run.
  - div_en = 1: tick = run & (pre_cnt == div_val).
- Counter:
  - On tick, cnt <= cnt + 1 at the next rising edge (1-cycle latency).
  - Wraps from all-ones to 0 with no flag.
- Writes:
  - cnt_wr_lo / cnt_wr_hi load the respective half at the next edge. They are accepted regardless of timer_en or halt_en.
  - Both strobes in the same cycle load both halves with the same wdata.
  - Write coinciding with tick: the write wins, no increment that cycle, and the unwritten half holds. Writes do not alter pre_cnt.
- Compare:
  - match = (cnt == cmp_val), evaluated on registered cnt.
  - int_st <= 1 on the edge after any cycle with match = 1. Level-based: re-sets every cycle the match persists, including while halted.
  - int_clr clears int_st. If int_clr and match occur in the same cycle, set wins.
  - int_st is independent of int_en. tim_int reflects int_en changes combinationally.
  - cmp_val = 0 out of reset sets int_st on the first clock after reset release. This is intended; software clears it.
- No combinational path from any input to cnt or int_st. The only combinational output is tim_int.

Decomposition:
- Shared package timer_pkg holds:
  - constants CNT_W and DIV_W defaults;
  - half-width constant HALF_W = CNT_W/2.
- One sub-module: timer_prescaler.
  - Inputs: clk, rst_n, timer_en, div_en, div_val, halt_en.
  - Output: tick.
  - Contains pre_cnt.
- Counter, write mux, compare and status logic stay in timer_cnt.

Test Plan:
- Reset with timer_en=1, div_en=0, cmp_val=max → cnt reads 0, 1, 2, 3 on successive clks after rst_n rises; int_st=0.
- div_en=1, div_val=3 → cnt increments once every 4 clks. 40 clks from 0 gives cnt=10. div_val=0 gives cnt=40.
- halt_en asserted for 10 clks mid-count (div_val=3, pre_cnt=2) → cnt and pre_cnt frozen. After release, the first increment occurs 2 clks later.
- cnt_wr_hi with wdata=0xFFFFFFFF then cnt_wr_lo with wdata=0xFFFFFFFE while counting → cnt = 0xFFFF_FFFF_FFFF_FFFE, then …FFFF, then 0 (wrap). A write coincident with a tick takes the written value with no +1.
- cmp_val=5, int_en=0 → int_st=1 on the edge after cnt==5 and tim_int=0. Raise int_en → tim_int=1 the same cycle. Pulse int_clr while cnt==5 is held by halt → int_st stays 1. After cnt moves on, int_clr → int_st=0.
- Assert rst_n low while cnt=0x1234 and int_st=1 → cnt=0 and int_st=0 immediately, without waiting for a clk edge.
